// File: rtl/codelock_pkg.sv
// Shared types and constants for the code-lock controller.
// Optional auto-relock is enabled by CODELOCK_AUTO_RELOCK_EN.
package codelock_pkg;

    localparam int DEF_DW     = 4;
    localparam int DEF_DIGITS = 4;
    localparam int BCD_MAX    = 9;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SETCODE = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    // First digit of the list lands in the most significant nibble.
    function automatic logic [DEF_DIGITS*DEF_DW-1:0] pack_code(
        input logic [DEF_DW-1:0] d [DEF_DIGITS]
    );
        logic [DEF_DIGITS*DEF_DW-1:0] w;
        w = '0;
        for (int i = 0; i < DEF_DIGITS; i++) begin
            w = {w[DEF_DIGITS*DEF_DW-DEF_DW-1:0], d[i]};
        end
        return w;
    endfunction

endpackage

// File: rtl/codelock_timer.sv
// Loadable down-counter shared by lockout and auto-relock
// (auto-relock only with CODELOCK_AUTO_RELOCK_EN).
module codelock_timer
#(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/codelock_ctrl.sv
// Code-lock sequencer: digit entry, check, lockout and code change.
// Define CODELOCK_AUTO_RELOCK_EN to relock OPEN after RELOCK_CYC idle cycles.
module codelock_ctrl
    import codelock_pkg::*;
#(
    parameter int DIGITS     = DEF_DIGITS,
    parameter int DW         = DEF_DW,
    parameter int MAX_TRIES  = 3,
    parameter int LOCK_CYC   = 24_000_000,
    parameter int RELOCK_CYC = 48_000_000,
    parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         digit_pulse,
    input  logic [DW-1:0]                digit_val,
    input  logic                         enter_pulse,
    input  logic                         clear_pulse,
    input  logic                         set_pulse,
    output logic                         unlocked,
    output logic                         alarm,
    output logic [1:0]                   err_cnt,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
    output logic [2:0]                   state,
    output logic [DIGITS*DW-1:0]         disp_code
);

    localparam int CW   = $clog2(DIGITS+1);
    localparam int BW   = DIGITS*DW;
    localparam int MAXC = (LOCK_CYC > RELOCK_CYC) ? LOCK_CYC : RELOCK_CYC;
    localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);
    localparam logic [CW-1:0] FULL    = CW'(DIGITS);
    localparam logic [1:0]    TRIES   = 2'(MAX_TRIES);

    state_e          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   code_q, code_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      err_q, err_d;
    logic            unl_q, alm_q;

    logic            t_load, t_en, t_zero;
    logic [TW-1:0]   t_val;

    logic            clr, ent, setp, dig;
    logic            dig_ok, dig_acc, match;

    // One winner per cycle: clear > enter > set > digit.
    assign clr  = clear_pulse;
    assign ent  = enter_pulse & ~clear_pulse;
    assign setp = set_pulse & ~clear_pulse & ~enter_pulse;
    assign dig  = digit_pulse & ~clear_pulse & ~enter_pulse & ~set_pulse;

    assign dig_ok  = 32'(digit_val) <= 32'(BCD_MAX);
    assign dig_acc = dig && dig_ok && (cnt_q != FULL);
    assign match   = (cnt_q == FULL) && (buf_q == code_q);

`ifdef CODELOCK_AUTO_RELOCK_EN
    localparam logic [TW-1:0] RELK_LD = TW'(RELOCK_CYC - 1);
    logic any_key;
    assign any_key = digit_pulse | enter_pulse | clear_pulse | set_pulse;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        t_load  = 1'b0;
        t_en    = 1'b0;
        t_val   = LOCK_LD;

        unique case (state_q)
            ST_LOCKED: begin
                if (clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (ent) begin
                    state_d = ST_CHECK;
                end else if (dig_acc) begin
                    buf_d = {buf_q[BW-DW-1:0], digit_val};
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (match) begin
                    state_d = ST_OPEN;
                    err_d   = '0;
`ifdef CODELOCK_AUTO_RELOCK_EN
                    t_load  = 1'b1;
                    t_val   = RELK_LD;
`endif
                end else begin
                    err_d = err_q + 2'd1;
                    if (err_d == TRIES) begin
                        state_d = ST_LOCKOUT;
                        t_load  = 1'b1;
                        t_val   = LOCK_LD;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end

            ST_OPEN: begin
                if (clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (ent) begin
                    state_d = ST_LOCKED;
                end else if (setp) begin
                    state_d = ST_SETCODE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
`ifdef CODELOCK_AUTO_RELOCK_EN
                // Any key restarts the idle window, even a dropped one.
                if (any_key) begin
                    t_load = 1'b1;
                    t_val  = RELK_LD;
                end else if (t_zero) begin
                    state_d = ST_LOCKED;
                end else begin
                    t_en = 1'b1;
                end
`endif
            end

            ST_SETCODE: begin
                if (clr) begin
                    state_d = ST_OPEN;
                    buf_d   = '0;
                    cnt_d   = '0;
`ifdef CODELOCK_AUTO_RELOCK_EN
                    t_load  = 1'b1;
                    t_val   = RELK_LD;
`endif
                end else if (ent) begin
                    if (cnt_q == FULL) begin
                        state_d = ST_OPEN;
                        code_d  = buf_q;
                        buf_d   = '0;
                        cnt_d   = '0;
`ifdef CODELOCK_AUTO_RELOCK_EN
                        t_load  = 1'b1;
                        t_val   = RELK_LD;
`endif
                    end
                end else if (dig_acc) begin
                    buf_d = {buf_q[BW-DW-1:0], digit_val};
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (t_zero) begin
                    state_d = ST_LOCKED;
                    err_d   = '0;
                end else begin
                    t_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOCKED;
            buf_q   <= '0;
            code_q  <= DEFAULT_CODE;
            cnt_q   <= '0;
            err_q   <= '0;
            unl_q   <= 1'b0;
            alm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            unl_q   <= (state_d == ST_OPEN) || (state_d == ST_SETCODE);
            alm_q   <= (state_d == ST_LOCKOUT);
        end
    end

    codelock_timer #(
        .TW(TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .en_i       (t_en),
        .load_val_i (t_val),
        .zero_o     (t_zero)
    );

    assign unlocked  = unl_q;
    assign alarm     = alm_q;
    assign err_cnt   = err_q;
    assign entry_cnt = cnt_q;
    assign state     = state_q;
    assign disp_code = buf_q;

endmodule

// File: tb/tb_codelock_ctrl.sv
// Bench for codelock_ctrl: fixed vector table, corner sequences and a
// randomized run against a behavioural model (CODELOCK_AUTO_RELOCK_EN aware).
module tb_codelock_ctrl;

    localparam int LCYC = 20;
    localparam int RCYC = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        digit_pulse = 1'b0;
    logic [3:0]  digit_val = '0;
    logic        enter_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic        set_pulse = 1'b0;
    logic        unlocked, alarm;
    logic [1:0]  err_cnt;
    logic [2:0]  entry_cnt;
    logic [2:0]  state;
    logic [15:0] disp_code;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    codelock_ctrl #(
        .DIGITS(4), .DW(4), .MAX_TRIES(3),
        .LOCK_CYC(LCYC), .RELOCK_CYC(RCYC),
        .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .rst(rst),
        .digit_pulse(digit_pulse), .digit_val(digit_val),
        .enter_pulse(enter_pulse), .clear_pulse(clear_pulse),
        .set_pulse(set_pulse),
        .unlocked(unlocked), .alarm(alarm), .err_cnt(err_cnt),
        .entry_cnt(entry_cnt), .state(state), .disp_code(disp_code)
    );

    // Behavioural model: 0 locked, 1 check, 2 open, 3 setcode, 4 lockout
    int m_st;
    int m_q[$];
    int m_code[4];
    int m_err;
    int m_lk;
    int m_idle;

    function automatic void model_reset();
        m_st = 0;
        m_q.delete();
        m_code = '{1, 2, 3, 4};
        m_err = 0;
        m_lk = 0;
        m_idle = 0;
    endfunction

    function automatic bit model_match();
        if (m_q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(bit c, bit e, bit s, bit d, int v);
        bit ok;
        bit anyk;
        anyk = c | e | s | d;
        case (m_st)
            0: begin
                if (c) m_q.delete();
                else if (e) m_st = 1;
                else if (s) ;
                else if (d && m_q.size() < 4 && v <= 9) m_q.push_back(v);
            end
            1: begin
                ok = model_match();
                m_q.delete();
                if (ok) begin
                    m_st = 2; m_err = 0; m_idle = 0;
                end else begin
                    m_err++;
                    if (m_err == 3) begin m_st = 4; m_lk = 0; end
                    else m_st = 0;
                end
            end
            2: begin
                if (c) m_q.delete();
                else if (e) m_st = 0;
                else if (s) begin m_st = 3; m_q.delete(); end
`ifdef CODELOCK_AUTO_RELOCK_EN
                if (m_st == 2) begin
                    if (anyk) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == RCYC) m_st = 0;
                    end
                end
`endif
            end
            3: begin
                if (c) begin
                    m_q.delete(); m_st = 2; m_idle = 0;
                end else if (e) begin
                    if (m_q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
                        m_q.delete(); m_st = 2; m_idle = 0;
                    end
                end else if (s) ;
                else if (d && m_q.size() < 4 && v <= 9) m_q.push_back(v);
            end
            default: begin
                m_lk++;
                if (m_lk == LCYC) begin m_st = 0; m_err = 0; end
            end
        endcase
        if (anyk == 1'b0 && m_st == -1) m_st = 0;
    endfunction

    function automatic logic [25:0] model_word();
        int dsp;
        dsp = 0;
        foreach (m_q[i]) dsp = dsp * 16 + m_q[i];
        return {3'(m_st), (m_st == 2 || m_st == 3), (m_st == 4),
                2'(m_err), 3'(m_q.size()), 16'(dsp)};
    endfunction

    function automatic logic [25:0] dut_word();
        return {state, unlocked, alarm, err_cnt, entry_cnt, disp_code};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(bit c, bit e, bit s, bit d, logic [3:0] v);
        clear_pulse = c;
        enter_pulse = e;
        set_pulse = s;
        digit_pulse = d;
        digit_val = v;
        @(posedge clk);
        #1;
        clear_pulse = 1'b0;
        enter_pulse = 1'b0;
        set_pulse = 1'b0;
        digit_pulse = 1'b0;
        model_step(c, e, s, d, int'(v));
        chk("model", 32'(dut_word()), 32'(model_word()));
    endtask

    task automatic enter_code(int a, int b, int c, int d);
        step(0, 0, 0, 1, 4'(a));
        step(0, 0, 0, 1, 4'(b));
        step(0, 0, 0, 1, 4'(c));
        step(0, 0, 0, 1, 4'(d));
        step(0, 1, 0, 0, 4'd0);
        step(0, 0, 0, 0, 4'd0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0);
    endtask

    task automatic async_reset(string nm);
        #2;
        rst = 1'b0;
        #1;
        chk(nm, 32'(dut_word()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst", 32'(dut_word()), 32'd0);
    endtask

    typedef struct {
        bit c, e, s, d;
        logic [3:0]  v;
        logic [2:0]  st;
        bit          un;
        logic [1:0]  er;
        logic [2:0]  ec;
        logic [15:0] dp;
    } vec_t;

    vec_t tbl[$];

    function automatic void tv(bit c, bit e, bit s, bit d, logic [3:0] v,
                               logic [2:0] st, bit un, logic [1:0] er,
                               logic [2:0] ec, logic [15:0] dp);
        vec_t t;
        t.c = c; t.e = e; t.s = s; t.d = d; t.v = v;
        t.st = st; t.un = un; t.er = er; t.ec = ec; t.dp = dp;
        tbl.push_back(t);
    endfunction

    initial begin
        int cnt;
        int k;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'(dut_word()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // unlock with default code
        tv(0,0,0,1,1, 0,0,0,1,16'h0001);
        tv(0,0,0,1,2, 0,0,0,2,16'h0012);
        tv(0,0,0,1,3, 0,0,0,3,16'h0123);
        tv(0,0,0,1,4, 0,0,0,4,16'h1234);
        tv(0,1,0,0,0, 1,0,0,4,16'h1234);
        tv(0,0,0,0,0, 2,1,0,0,16'h0000);
        // setcode aborted by clear beating enter
        tv(0,0,1,0,0, 3,1,0,0,16'h0000);
        tv(0,0,0,1,5, 3,1,0,1,16'h0005);
        tv(0,0,0,1,6, 3,1,0,2,16'h0056);
        tv(1,1,0,0,0, 2,1,0,0,16'h0000);
        tv(0,1,0,0,0, 0,0,0,0,16'h0000);
        tv(0,0,0,1,1, 0,0,0,1,16'h0001);
        tv(0,0,0,1,2, 0,0,0,2,16'h0012);
        tv(0,0,0,1,3, 0,0,0,3,16'h0123);
        tv(0,0,0,1,4, 0,0,0,4,16'h1234);
        tv(0,1,0,0,0, 1,0,0,4,16'h1234);
        tv(0,0,0,0,0, 2,1,0,0,16'h0000);
        // change code to 9876
        tv(0,0,1,0,0, 3,1,0,0,16'h0000);
        tv(0,0,0,1,9, 3,1,0,1,16'h0009);
        tv(0,0,0,1,8, 3,1,0,2,16'h0098);
        tv(0,0,0,1,7, 3,1,0,3,16'h0987);
        tv(0,0,0,1,6, 3,1,0,4,16'h9876);
        tv(0,1,0,0,0, 2,1,0,0,16'h0000);
        tv(0,1,0,0,0, 0,0,0,0,16'h0000);
        tv(0,0,0,1,1, 0,0,0,1,16'h0001);
        tv(0,0,0,1,2, 0,0,0,2,16'h0012);
        tv(0,0,0,1,3, 0,0,0,3,16'h0123);
        tv(0,0,0,1,4, 0,0,0,4,16'h1234);
        tv(0,1,0,0,0, 1,0,0,4,16'h1234);
        tv(0,0,0,0,0, 0,0,1,0,16'h0000);
        tv(0,0,0,1,9, 0,0,1,1,16'h0009);
        tv(0,0,0,1,8, 0,0,1,2,16'h0098);
        tv(0,0,0,1,7, 0,0,1,3,16'h0987);
        tv(0,0,0,1,6, 0,0,1,4,16'h9876);
        tv(0,1,0,0,0, 1,0,1,4,16'h9876);
        tv(0,0,0,0,0, 2,1,0,0,16'h0000);
        tv(0,1,0,0,0, 0,0,0,0,16'h0000);
        // short entry fails, then saturation
        tv(0,0,0,1,1, 0,0,0,1,16'h0001);
        tv(0,0,0,1,2, 0,0,0,2,16'h0012);
        tv(0,0,0,1,3, 0,0,0,3,16'h0123);
        tv(0,1,0,0,0, 1,0,0,3,16'h0123);
        tv(0,0,0,0,0, 0,0,1,0,16'h0000);
        tv(0,0,0,1,1, 0,0,1,1,16'h0001);
        tv(0,0,0,1,2, 0,0,1,2,16'h0012);
        tv(0,0,0,1,3, 0,0,1,3,16'h0123);
        tv(0,0,0,1,4, 0,0,1,4,16'h1234);
        tv(0,0,0,1,5, 0,0,1,4,16'h1234);
        tv(1,0,0,0,0, 0,0,1,0,16'h0000);
        tv(0,0,0,1,4'hA, 0,0,1,0,16'h0000);
        tv(0,0,0,1,7, 0,0,1,1,16'h0007);
        tv(0,1,0,1,3, 1,0,1,1,16'h0007);
        tv(0,0,0,0,0, 0,0,2,0,16'h0000);
        tv(1,0,0,1,5, 0,0,2,0,16'h0000);
        tv(0,0,0,1,1, 0,0,2,1,16'h0001);
        tv(0,0,0,1,2, 0,0,2,2,16'h0012);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].c, tbl[i].e, tbl[i].s, tbl[i].d, tbl[i].v);
            chk($sformatf("tbl%0d", i), 32'(dut_word()),
                32'({tbl[i].st, tbl[i].un, 1'b0, tbl[i].er,
                     tbl[i].ec, tbl[i].dp}));
        end

        // asynchronous reset mid-entry; changed code must revert
        async_reset("async_rst");

        // three failures -> lockout of exactly LCYC cycles
        enter_code(1, 2, 3, 5);
        chk("fail1_err", 32'(err_cnt), 32'd1);
        enter_code(1, 2, 3, 5);
        chk("fail2_err", 32'(err_cnt), 32'd2);
        enter_code(1, 2, 3, 5);
        chk("lockout_st", 32'(state), 32'd4);
        cnt = alarm ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin
                step(0, 0, 0, 1, 4'd7);
                chk("lock_dig", 32'(entry_cnt), 32'd0);
            end else begin
                step(0, 0, 0, 0, 4'd0);
            end
            if (alarm) cnt++;
            else break;
        end
        chk("lock_len", 32'(cnt), 32'(LCYC));
        chk("lock_exit", 32'({state, err_cnt}), 32'd0);

        enter_code(1, 2, 3, 4);
        chk("code_revert", 32'({state, unlocked}), 32'h5);

`ifdef CODELOCK_AUTO_RELOCK_EN
        idle(RCYC - 1);
        chk("relock_hold", 32'(state), 32'd2);
        idle(1);
        chk("relock", 32'(state), 32'd0);
        enter_code(1, 2, 3, 4);
        idle(24);
        step(0, 0, 0, 1, 4'd3);
        idle(RCYC - 1);
        chk("relock_rst_hold", 32'(state), 32'd2);
        idle(1);
        chk("relock_rst", 32'(state), 32'd0);
`endif

        // randomized episodes against the model
        for (int ep = 0; ep < 400; ep++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
                3, 4: begin
                    cnt = $urandom_range(0, 5);
                    for (int j = 0; j < cnt; j++)
                        step(0, 0, 0, 1, 4'($urandom_range(0, 11)));
                    step(0, 1, 0, 0, 4'd0);
                    step(0, 0, 0, 0, 4'd0);
                end
                5: begin
                    step(0, 0, 1, 0, 4'd0);
                    cnt = $urandom_range(0, 5);
                    for (int j = 0; j < cnt; j++)
                        step(0, 0, 0, 1, 4'($urandom_range(0, 11)));
                    if ($urandom_range(0, 3) == 0) step(1, 0, 0, 0, 4'd0);
                    else step(0, 1, 0, 0, 4'd0);
                end
                6: begin
                    for (int j = 0; j < 3; j++)
                        step(1'($urandom_range(0, 3) == 0),
                             1'($urandom_range(0, 2) == 0),
                             1'($urandom_range(0, 2) == 0),
                             1'($urandom_range(0, 1)),
                             4'($urandom_range(0, 15)));
                end
                7: idle($urandom_range(1, 35));
                8: step(0, 1, 0, 0, 4'd0);
                default: begin
                    if ($urandom_range(0, 3) == 0) async_reset("rand_rst");
                    else step(0, 0, 0, 1, 4'($urandom_range(0, 9)));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
